double_to_sig16b: RTL and testbench

DOUBLE_TO_SIG16B -- requirements
Module: double_to_sig16b

---
 rtl/double_to_sig16b.sv | 98 +++++++++
 tb/tb_double_to_sig16b.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/double_to_sig16b.sv
// rtl/double_to_sig16b.sv - IEEE-754 binary64 to saturated 16-bit integer, frame-gated output
module double_to_sig16b #(
    parameter int LATENCY = 3
) (
    input  logic        clk_operation,
    input  logic        rst,
    input  logic [12:0] sampling_cycle_counter,
    input  logic        enable,
    input  logic [63:0] double,
    output logic [15:0] sig16b
);

    // valid[0]: captured operand, valid[1]: unpacked, valid[2]: aligned/rounded
    logic [LATENCY-1:0] valid;
    logic [63:0]        cap;

    logic               sign1;
    logic [10:0]        exp1;
    logic [52:0]        mant1;

    logic               sign2;
    logic               zero2;
    logic               ovf2;
    logic [16:0]        mag2;

    logic [15:0]        result;

    logic               nan_c;
    logic               zero_c;
    logic               ovf_c;
    logic [5:0]         shamt;
    logic [16:0]        sx2;
    logic [16:0]        mag_c;
    logic [15:0]        result_c;

    // Shift keeps one bit below the binary point as the round bit; e=-1 lands at shift 52
    always_comb begin
        nan_c  = (exp1 == 11'h7FF) && (|mant1[51:0]);
        zero_c = (exp1 < 11'd1022) || nan_c;
        ovf_c  = (exp1 > 11'd1038) && !nan_c;
        shamt  = 6'(11'd1074 - exp1);
        sx2    = 17'(mant1 >> shamt);
        mag_c  = {1'b0, sx2[16:1]} + {16'd0, sx2[0]};
    end

    always_comb begin
        result_c = 16'h0000;
        if (zero2) begin
            result_c = 16'h0000;
        end else if (ovf2) begin
            result_c = sign2 ? 16'h8000 : 16'h7FFF;
        end else if (sign2) begin
            result_c = (mag2 > 17'd32768) ? 16'h8000 : 16'(~mag2[15:0] + 16'd1);
        end else begin
            result_c = (mag2 > 17'd32767) ? 16'h7FFF : mag2[15:0];
        end
    end

    always_ff @(posedge clk_operation or posedge rst) begin
        if (rst) begin
            valid  <= '0;
            cap    <= '0;
            sign1  <= 1'b0;
            exp1   <= '0;
            mant1  <= '0;
            sign2  <= 1'b0;
            zero2  <= 1'b0;
            ovf2   <= 1'b0;
            mag2   <= '0;
            result <= '0;
            sig16b <= '0;
        end else begin
            valid <= {valid[LATENCY-2:0], enable};
            if (enable) begin
                cap <= double;
            end
            if (valid[0]) begin
                sign1 <= cap[63];
                exp1  <= cap[62:52];
                mant1 <= {|cap[62:52], cap[51:0]};
            end
            if (valid[1]) begin
                sign2 <= sign1;
                zero2 <= zero_c;
                ovf2  <= ovf_c;
                mag2  <= mag_c;
            end
            if (valid[LATENCY-1]) begin
                result <= result_c;
            end
            // Takes the pre-edge result, so a same-edge write shows one frame later
            if (sampling_cycle_counter == 13'd0) begin
                sig16b <= result;
            end
        end
    end

endmodule

// File: tb/tb_double_to_sig16b.sv
// tb/tb_double_to_sig16b.sv - randomized model-checked bench for double_to_sig16b
module tb_double_to_sig16b;

    logic        clk_operation = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] sampling_cycle_counter = 13'd0;
    logic        enable = 1'b0;
    logic [63:0] double = 64'd0;
    logic [15:0] sig16b;

    int total = 0;
    int bad = 0;
    int frame_len = 8;
    bit rand_frames = 1'b0;

    typedef struct {
        logic        v;
        logic [63:0] d;
    } op_t;

    op_t         pipe_q[$];
    logic [15:0] m_res = 16'h0;
    logic [15:0] m_sig = 16'h0;

    double_to_sig16b #(.LATENCY(3)) dut (
        .clk_operation(clk_operation),
        .rst(rst),
        .sampling_cycle_counter(sampling_cycle_counter),
        .enable(enable),
        .double(double),
        .sig16b(sig16b)
    );

    always #5 clk_operation = ~clk_operation;

    function automatic logic [15:0] conv(input logic [63:0] b);
        real v;
        real a;
        real f;
        int  r;
        v = $bitstoreal(b);
        if (v != v) return 16'h0000;
        a = (v < 0.0) ? -v : v;
        if (a >= 40000.0) begin
            r = 40000;
        end else begin
            f = $floor(a);
            r = int'(f) + (((a - f) >= 0.5) ? 1 : 0);
        end
        if (v < 0.0) r = -r;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return 16'(r);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=0x%04h required=0x%04h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        pipe_q.delete();
        for (int i = 0; i < 3; i++) pipe_q.push_back('{v: 1'b0, d: 64'd0});
        m_res = 16'h0;
        m_sig = 16'h0;
    endtask

    // Output takes the old result at a boundary; result takes the operand from three edges ago
    task automatic model_edge();
        op_t         old;
        logic [15:0] ns;
        ns = (sampling_cycle_counter == 13'd0) ? m_res : m_sig;
        old = pipe_q.pop_front();
        if (old.v) m_res = conv(old.d);
        pipe_q.push_back('{v: enable, d: double});
        m_sig = ns;
    endtask

    task automatic step(input logic en, input logic [63:0] d);
        enable = en;
        double = d;
        @(posedge clk_operation);
        if (!rst) model_edge();
        #1;
        check("sig16b_vs_model", sig16b, m_sig);
        if (sampling_cycle_counter >= 13'(frame_len - 1)) begin
            sampling_cycle_counter = 13'd0;
            if (rand_frames) frame_len = $urandom_range(1, 10);
        end else begin
            sampling_cycle_counter = sampling_cycle_counter + 13'd1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, {$urandom, $urandom});
    endtask

    task automatic sync_to(input int c);
        for (int i = 0; i < 64 && sampling_cycle_counter != 13'(c); i++) idle(1);
        check("sync_to_counter", {3'b0, sampling_cycle_counter}, 16'(c));
    endtask

    task automatic lit(input string name, input logic [63:0] d, input logic [15:0] req);
        check({name, "_model"}, conv(d), req);
        step(1'b1, d);
        idle(17);
        check({name, "_dut"}, sig16b, req);
    endtask

    function automatic logic [63:0] rand_double();
        int sel;
        sel = $urandom_range(0, 99);
        if (sel < 65) return {1'($urandom), 11'($urandom_range(1015, 1045)), $urandom, 20'($urandom)};
        if (sel < 75) return {1'($urandom), 11'($urandom_range(1018, 1040)), 4'($urandom), 48'd0};
        if (sel < 85) begin
            case ($urandom_range(0, 5))
                0: return 64'h7FF0000000000000;
                1: return 64'hFFF0000000000000;
                2: return 64'h7FF8000000000001;
                3: return 64'h8000000000000000;
                4: return 64'h000FFFFFFFFFFFFF;
                default: return 64'hC0E0000000000000;
            endcase
        end
        return {$urandom, $urandom};
    endfunction

    task automatic reset_pulse(input int cycles);
        #2 rst = 1'b1;
        #1;
        check("sig16b_async_reset", sig16b, 16'h0000);
        model_clear();
        for (int i = 0; i < cycles; i++) step(1'($urandom), {$urandom, $urandom});
        #2 rst = 1'b0;
    endtask

    initial begin
        model_clear();
        #1;
        check("sig16b_reset_state", sig16b, 16'h0000);
        idle(2);
        #2 rst = 1'b0;

        lit("ten_thousand", 64'h40C3880000000000, 16'h2710);
        lit("round_1p5", 64'h3FF8000000000000, 16'h0002);
        lit("round_2p5", 64'h4004000000000000, 16'h0003);
        lit("round_m1p5", 64'hBFF8000000000000, 16'hFFFE);
        lit("round_0p4", 64'h3FD999999999999A, 16'h0000);
        lit("sat_40000", 64'h40E3880000000000, 16'h7FFF);
        lit("sat_m40000", 64'hC0E3880000000000, 16'h8000);
        lit("exact_m32768", 64'hC0E0000000000000, 16'h8000);
        lit("pos_inf", 64'h7FF0000000000000, 16'h7FFF);
        lit("qnan", 64'h7FF8000000000000, 16'h0000);
        lit("neg_zero", 64'h8000000000000000, 16'h0000);
        lit("half", 64'h3FE0000000000000, 16'h0001);
        lit("neg_inf", 64'hFFF0000000000000, 16'h8000);
        lit("ten_thousand_again", 64'h40C3880000000000, 16'h2710);

        // Capture at counter 5 so the result lands on the boundary edge
        sync_to(5);
        step(1'b1, 64'h3FF8000000000000);
        idle(3);
        check("same_edge_keeps_old", sig16b, 16'h2710);
        idle(8);
        check("same_edge_next_frame", sig16b, 16'h0002);

        // Back-to-back captures: last one written before the boundary wins
        sync_to(1);
        step(1'b1, 64'h40C3880000000000);
        step(1'b1, 64'h4004000000000000);
        idle(10);
        check("back_to_back_last", sig16b, 16'h0003);

        lit("reload_10000", 64'h40C3880000000000, 16'h2710);
        step(1'b1, 64'h40E3880000000000);
        reset_pulse(2);
        idle(20);
        check("reset_no_capture_stays_zero", sig16b, 16'h0000);

        rand_frames = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0), rand_double());
            if ($urandom_range(0, 499) == 0) reset_pulse($urandom_range(1, 3));
        end
        idle(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
